// File: rtl/top.sv
`default_nettype none
// ============================================================================
// Module  : top
// Brief   : BCD 24h clock with set button, and a 16-pixel WS2812 HH:MM display.
// Revision: 1.0 - initial release
// ============================================================================
module top #(
    parameter int MAIN_CLK = 12000000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       CLK_1HZ,
    input  logic       BTN,
    output logic [4:0] LED,
    output logic       WS2812_DATA
);

    function automatic logic [31:0] f_cycles(input longint num, input longint den);
        longint v;
        v = (longint'(MAIN_CLK) * num) / den;
        return (v < 64'sd1) ? 32'd1 : v[31:0];
    endfunction

    localparam logic [31:0] c_BIT_CYC = f_cycles(125, 100000000);
    localparam logic [31:0] c_HIGH1   = f_cycles(80, 100000000);
    localparam logic [31:0] c_HIGH0   = f_cycles(40, 100000000);
    localparam logic [31:0] c_GAP     = f_cycles(60, 1000000);
    localparam logic [31:0] c_LOW1    = (c_BIT_CYC > c_HIGH1) ? c_BIT_CYC - c_HIGH1 : 32'd1;
    localparam logic [31:0] c_LOW0    = (c_BIT_CYC > c_HIGH0) ? c_BIT_CYC - c_HIGH0 : 32'd1;

    logic [3:0] dh1, dh0, dm1, dm0, ds1, ds0;
    logic [3:0] dh1_d, dh0_d, dm1_d, dm0_d, ds1_d, ds0_d;
    logic       btn_low_q;
    logic       w_min_inc, w_hr_inc;

    always_comb begin
        dh1_d     = dh1;
        dh0_d     = dh0;
        dm1_d     = dm1;
        dm0_d     = dm0;
        ds1_d     = ds1;
        ds0_d     = ds0;
        w_min_inc = 1'b0;
        w_hr_inc  = 1'b0;
        if (BTN) begin
            if (ds0 == 4'd9) begin
                ds0_d = 4'd0;
                if (ds1 == 4'd5) begin
                    ds1_d     = 4'd0;
                    w_min_inc = 1'b1;
                end else begin
                    ds1_d = ds1 + 4'd1;
                end
            end else begin
                ds0_d = ds0 + 4'd1;
            end
        end else begin
            ds0_d     = 4'd0;
            ds1_d     = 4'd0;
            w_min_inc = 1'b1;
        end
        if (w_min_inc) begin
            if (dm0 == 4'd9) begin
                dm0_d = 4'd0;
                if (dm1 == 4'd5) begin
                    dm1_d    = 4'd0;
                    w_hr_inc = 1'b1;
                end else begin
                    dm1_d = dm1 + 4'd1;
                end
            end else begin
                dm0_d = dm0 + 4'd1;
            end
        end
        if (w_hr_inc) begin
            if (dh1 == 4'd2 && dh0 == 4'd3) begin
                dh1_d = 4'd0;
                dh0_d = 4'd0;
            end else if (dh0 == 4'd9) begin
                dh0_d = 4'd0;
                dh1_d = dh1 + 4'd1;
            end else begin
                dh0_d = dh0 + 4'd1;
            end
        end
    end

    always_ff @(posedge CLK_1HZ or negedge RST_N) begin
        if (!RST_N) begin
            dh1       <= 4'd0;
            dh0       <= 4'd0;
            dm1       <= 4'd0;
            dm0       <= 4'd0;
            ds1       <= 4'd0;
            ds0       <= 4'd0;
            btn_low_q <= 1'b0;
        end else begin
            dh1       <= dh1_d;
            dh0       <= dh0_d;
            dm1       <= dm1_d;
            dm0       <= dm0_d;
            ds1       <= ds1_d;
            ds0       <= ds0_d;
            btn_low_q <= ~BTN;
        end
    end

    assign LED = {btn_low_q, ds0};

    // Displayed digits cross from the 1 Hz domain; seconds are not shown.
    logic [15:0] sync1_q, sync2_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q <= 16'd0;
            sync2_q <= 16'd0;
        end else begin
            sync1_q <= {dh1, dh0, dm1, dm0};
            sync2_q <= sync1_q;
        end
    end

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        SEND_HIGH = 3'd2,
        SEND_LOW  = 3'd3,
        LATCH     = 3'd4
    } state_t;

    state_t      state_q;
    logic [31:0] cnt_q;
    logic [3:0]  pix_q;
    logic [4:0]  bit_q;
    logic [15:0] snap_q;
    logic        data_q;

    logic [3:0]  w_digit;
    logic        w_bit_one;
    logic        w_last_bit;
    logic [31:0] w_high_cyc;
    logic [31:0] w_low_cyc;

    always_comb begin
        w_digit = 4'd0;
        case (pix_q[3:2])
            2'd0:    w_digit = snap_q[15:12];
            2'd1:    w_digit = snap_q[11:8];
            2'd2:    w_digit = snap_q[7:4];
            default: w_digit = snap_q[3:0];
        endcase
    end

    // A lit pixel is GRB 00_20_00: only the 11th transmitted bit (R bit 5) is set.
    assign w_bit_one  = w_digit[pix_q[1:0]] && (bit_q == 5'd10);
    assign w_last_bit = (pix_q == 4'd15) && (bit_q == 5'd23);
    assign w_high_cyc = w_bit_one ? c_HIGH1 : c_HIGH0;
    assign w_low_cyc  = w_bit_one ? c_LOW1  : c_LOW0;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= 32'd0;
            pix_q   <= 4'd0;
            bit_q   <= 5'd0;
            snap_q  <= 16'd0;
            data_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    data_q  <= 1'b0;
                    state_q <= LOAD;
                end
                LOAD: begin
                    snap_q  <= sync2_q;
                    pix_q   <= 4'd0;
                    bit_q   <= 5'd0;
                    cnt_q   <= 32'd0;
                    data_q  <= 1'b1;
                    state_q <= SEND_HIGH;
                end
                SEND_HIGH: begin
                    if (cnt_q >= w_high_cyc - 32'd1) begin
                        cnt_q   <= 32'd0;
                        data_q  <= 1'b0;
                        state_q <= SEND_LOW;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                SEND_LOW: begin
                    if (cnt_q >= w_low_cyc - 32'd1) begin
                        cnt_q <= 32'd0;
                        if (w_last_bit) begin
                            state_q <= LATCH;
                        end else begin
                            if (bit_q == 5'd23) begin
                                bit_q <= 5'd0;
                                pix_q <= pix_q + 4'd1;
                            end else begin
                                bit_q <= bit_q + 5'd1;
                            end
                            data_q  <= 1'b1;
                            state_q <= SEND_HIGH;
                        end
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                LATCH: begin
                    if (cnt_q >= c_GAP - 32'd1) begin
                        cnt_q   <= 32'd0;
                        state_q <= LOAD;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                default: begin
                    data_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign WS2812_DATA = data_q;

endmodule
`default_nettype wire

// File: tb/tb_top.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_top
// Brief   : Self-checking bench for top: clock counting, set mode, WS2812 frame.
// Revision: 1.0 - initial release
// ============================================================================
module tb_top;

    logic       CLK     = 1'b0;
    logic       RST_N   = 1'b1;
    logic       CLK_1HZ = 1'b0;
    logic       BTN     = 1'b1;
    logic [4:0] LED;
    logic       WS2812_DATA;

    int checks   = 0;
    int failures = 0;
    int ref_sec  = 0;

    top #(.MAIN_CLK(12000000)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .CLK_1HZ     (CLK_1HZ),
        .BTN         (BTN),
        .LED         (LED),
        .WS2812_DATA (WS2812_DATA)
    );

    always #5 CLK = ~CLK;

    // Reference clock: seconds-of-day as a plain integer.
    function automatic logic [23:0] model_bcd(input int s);
        int h, m, sec;
        h   = s / 3600;
        m   = (s / 60) % 60;
        sec = s % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(sec / 10), 4'(sec % 10)};
    endfunction

    function automatic logic [23:0] dut_time();
        return {dut.dh1, dut.dh0, dut.dm1, dut.dm0, dut.ds1, dut.ds0};
    endfunction

    task automatic do_tick(input logic b);
        CLK_1HZ = 1'b0;
        BTN     = b;
        #1;
        CLK_1HZ = 1'b1;
        #1;
        if (b) ref_sec = (ref_sec + 1) % 86400;
        else   ref_sec = (((ref_sec / 60) + 1) % 1440) * 60;
    endtask

    task automatic apply_reset();
        RST_N   = 1'b0;
        CLK_1HZ = 1'b0;
        BTN     = 1'b1;
        #7;
        ref_sec = 0;
        RST_N   = 1'b1;
        #3;
    endtask

    task automatic test_reset();
        #2;
        RST_N = 1'b0;
        #20;
        BTN = 1'b0;
        CLK_1HZ = 1'b1;
        #3;
        CLK_1HZ = 1'b0;
        BTN = 1'b1;
        #20;
        checks++;
        if (dut_time() !== 24'h000000) begin
            failures++;
            $display("FAIL reset_time got=%h want=000000", dut_time());
        end
        checks++;
        if (LED !== 5'b00000) begin
            failures++;
            $display("FAIL reset_led got=%b want=00000", LED);
        end
        checks++;
        if (WS2812_DATA !== 1'b0) begin
            failures++;
            $display("FAIL reset_ws got=%b want=0", WS2812_DATA);
        end
        #2;
        ref_sec = 0;
        RST_N = 1'b1;
        #3;
    endtask

    task automatic test_carry();
        apply_reset();
        repeat (59) do_tick(1'b1);
        checks++;
        if (dut_time() !== 24'h000059) begin
            failures++;
            $display("FAIL carry_00_00_59 got=%h want=000059", dut_time());
        end
        do_tick(1'b1);
        checks++;
        if (dut_time() !== 24'h000100) begin
            failures++;
            $display("FAIL carry_min got=%h want=000100", dut_time());
        end
        apply_reset();
        repeat (59) do_tick(1'b0);
        repeat (59) do_tick(1'b1);
        checks++;
        if (dut_time() !== 24'h005959) begin
            failures++;
            $display("FAIL carry_00_59_59 got=%h want=005959", dut_time());
        end
        do_tick(1'b1);
        checks++;
        if (dut_time() !== 24'h010000) begin
            failures++;
            $display("FAIL carry_hour got=%h want=010000", dut_time());
        end
    endtask

    task automatic test_set_mode();
        apply_reset();
        for (int i = 0; i < 300; i++) begin
            do_tick(1'b0);
            checks++;
            if ({LED[4], dut.ds1, dut.ds0} !== 9'h100 || dut_time() !== model_bcd(ref_sec)) begin
                failures++;
                $display("FAIL set_tick%0d led4/sec/time got=%b/%h/%h want=1/00/%h",
                         i, LED[4], {dut.ds1, dut.ds0}, dut_time(), model_bcd(ref_sec));
            end
        end
        checks++;
        if (dut_time() !== 24'h050000) begin
            failures++;
            $display("FAIL set_300 got=%h want=050000", dut_time());
        end
    endtask

    task automatic test_rollover();
        int  mism;
        bit  seen23, wrapped;
        logic [23:0] first_bad;
        mism = 0; seen23 = 0; wrapped = 0; first_bad = '0;
        apply_reset();
        for (int i = 0; i < 86400; i++) begin
            do_tick(1'b1);
            if (dut_time() !== model_bcd(ref_sec)) begin
                if (mism == 0) first_bad = dut_time();
                mism++;
            end
            if ({dut.dh1, dut.dh0} == 8'h23) seen23 = 1;
            if (seen23 && {dut.dh1, dut.dh0} == 8'h00) wrapped = 1;
        end
        checks++;
        if (mism != 0) begin
            failures++;
            $display("FAIL rollover_track mismatches=%0d first_got=%h want=0", mism, first_bad);
        end
        checks++;
        if (!(seen23 && wrapped)) begin
            failures++;
            $display("FAIL rollover_23_then_00 got seen23=%0d wrapped=%0d want=1/1", seen23, wrapped);
        end
        checks++;
        if (dut_time() !== 24'h000000) begin
            failures++;
            $display("FAIL rollover_final got=%h want=000000", dut_time());
        end
    endtask

    task automatic test_random();
        logic b;
        logic [23:0] exp_t;
        logic [4:0]  exp_led;
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            b = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
            do_tick(b);
            exp_t   = model_bcd(ref_sec);
            exp_led = {~b, exp_t[3:0]};
            checks++;
            if (dut_time() !== exp_t || LED !== exp_led) begin
                failures++;
                $display("FAIL random_tick%0d time/led got=%h/%b want=%h/%b",
                         i, dut_time(), LED, exp_t, exp_led);
            end
        end
    endtask

    task automatic test_frame();
        int run, guard, h, l, bad_hi, bad_per, hr, mn, e;
        int hi_w[384];
        int lo_w[384];
        int dig[4];
        logic [23:0] got_w, exp_w;
        apply_reset();
        repeat (754) do_tick(1'b0);
        checks++;
        if (dut_time() !== 24'h123400) begin
            failures++;
            $display("FAIL frame_preset got=%h want=123400", dut_time());
        end
        hr = ref_sec / 3600;
        mn = (ref_sec / 60) % 60;
        dig[0] = hr / 10; dig[1] = hr % 10; dig[2] = mn / 10; dig[3] = mn % 10;
        repeat (5) @(negedge CLK);
        run = 0; guard = 0;
        while (run < 600 && guard < 20000) begin
            @(negedge CLK);
            guard++;
            run = WS2812_DATA ? 0 : run + 1;
        end
        while (!WS2812_DATA && guard < 20000) begin
            @(negedge CLK);
            guard++;
        end
        checks++;
        if (guard >= 20000) begin
            failures++;
            $display("FAIL frame_start_timeout got=%0d cycles want<20000", guard);
            return;
        end
        for (int k = 0; k < 384; k++) begin
            h = 0;
            while (WS2812_DATA && h < 100) begin h++; @(negedge CLK); end
            l = 0;
            while (!WS2812_DATA && l < 2000) begin l++; @(negedge CLK); end
            hi_w[k] = h;
            lo_w[k] = l;
        end
        bad_hi = 0; bad_per = 0;
        for (int p = 0; p < 16; p++) begin
            exp_w = ((dig[p / 4] >> (p % 4)) & 1) != 0 ? 24'h002000 : 24'h000000;
            got_w = '0;
            for (int b = 0; b < 24; b++) begin
                got_w = {got_w[22:0], (hi_w[p*24+b] >= 7) ? 1'b1 : 1'b0};
                e = exp_w[23-b] ? 9 : 4;
                if (hi_w[p*24+b] != e) bad_hi++;
                if (p*24+b < 383 && hi_w[p*24+b] + lo_w[p*24+b] != 15) bad_per++;
            end
            checks++;
            if (got_w !== exp_w) begin
                failures++;
                $display("FAIL frame_pixel%0d got=%h want=%h", p, got_w, exp_w);
            end
        end
        checks++;
        if (bad_hi != 0) begin
            failures++;
            $display("FAIL frame_high_width bad_bits=%0d want=0 (bit0 high=%0d)", bad_hi, hi_w[0]);
        end
        checks++;
        if (bad_per != 0) begin
            failures++;
            $display("FAIL frame_bit_period bad_bits=%0d want=0 (bit0 period=%0d)", bad_per, hi_w[0] + lo_w[0]);
        end
        checks++;
        if (lo_w[383] < 720) begin
            failures++;
            $display("FAIL frame_latch_gap got=%0d cycles want>=720", lo_w[383]);
        end
    endtask

    task automatic test_reset_midframe();
        int guard, n, h;
        guard = 0;
        @(negedge CLK);
        while (!WS2812_DATA && guard < 20000) begin @(negedge CLK); guard++; end
        #1;
        RST_N = 1'b0;
        #1;
        checks++;
        if (WS2812_DATA !== 1'b0 || dut_time() !== 24'h000000 || LED !== 5'b00000) begin
            failures++;
            $display("FAIL midframe_reset ws/time/led got=%b/%h/%b want=0/000000/00000",
                     WS2812_DATA, dut_time(), LED);
        end
        #20;
        ref_sec = 0;
        RST_N = 1'b1;
        n = 0;
        @(negedge CLK);
        while (!WS2812_DATA && n < 10) begin @(negedge CLK); n++; end
        h = 0;
        while (WS2812_DATA && h < 100) begin h++; @(negedge CLK); end
        checks++;
        if (n >= 10 || h != 4) begin
            failures++;
            $display("FAIL midframe_restart wait/high got=%0d/%0d want<10/4", n, h);
        end
    endtask

    initial begin
        test_reset();
        test_carry();
        test_set_mode();
        test_rollover();
        test_random();
        test_frame();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 Parameter MAIN_CLK, default 12000000, CLK frequency in Hz; used only to derive WS2812 bit timing.
REQ-002 CLK  input  1  sole system clock; all WS2812 serialiser logic is clocked on its rising edge.
REQ-003 RST_N  input  1  reset; asynchronous, active-low; clears every register in the block.
REQ-004 CLK_1HZ  input  1  timebase; each rising edge is one time tick. Time registers are clocked by this edge and share RST_N.
REQ-005 BTN  input  1  set button, active-low; 1 = released.
REQ-006 LED  output  5  status: LED[3:0] = seconds units (ds0), LED[4] = 1 while BTN is low (sampled).
REQ-007 WS2812_DATA  output  1  serial data to a 16-pixel WS2812 chain.

Function
REQ-008 Time is held as BCD registers named dh1, dh0, dm1, dm0, ds1, ds0, each 4 bits wide, so a bench can probe them hierarchically: hours tens/units, minutes tens/units, seconds tens/units.
REQ-009 Normal tick (BTN high at the CLK_1HZ edge): increment seconds.
- ds0 wraps 9->0 with carry into ds1.
- ds1 wraps 5->0 with carry into minutes.
- Minutes wrap 59->00 with carry into hours.
- Hours wrap 23->00; no date carry.
REQ-010 Set tick (BTN low at the CLK_1HZ edge):
- Seconds are forced to 00.
- Minutes increment by one, with normal minute/hour carry and 23:59->00:00 wrap.
- Advancing 00:00 to 05:00 takes 300 set ticks.
REQ-011 BTN is sampled only at CLK_1HZ rising edges; no further debounce is applied.
REQ-012 Invalid BCD values cannot occur. Each digit increments only from its legal range.
REQ-013 The display is 16 pixels, pixel index p = 4*col + row:
- col 0..3 = dh1, dh0, dm1, dm0.
- row r = bit r of that digit.
REQ-014 Pixel colour is sent GRB, MSB first, 24 bits per pixel:
- bit set -> G=0x00, R=0x20, B=0x00.
- bit clear -> all zero.
REQ-015 The time digits are brought into the CLK domain through a two-flop synchroniser. They are snapshotted at the start of each frame and are stable for that frame.
REQ-016 Frame sequence: pixels 0..15 (384 bits), then a low latch gap of at least 60 us, then repeat continuously.
REQ-017 Bit timing, with cycle counts computed from MAIN_CLK by integer arithmetic and each clamped to a minimum of 1 cycle:
- Bit period T = MAIN_CLK*1.25 us.
- A '1' is high for MAIN_CLK*0.8 us, then low for the rest of T.
- A '0' is high for MAIN_CLK*0.4 us, then low for the rest of T.
REQ-018 The serialiser FSM has states IDLE, LOAD, SEND_HIGH, SEND_LOW, LATCH.
- IDLE -> LOAD always.
- LOAD snapshots the digits and clears the bit/pixel counters, then goes to SEND_HIGH.
- SEND_HIGH -> SEND_LOW after the high count for the current bit.
- SEND_LOW -> SEND_HIGH for the next bit, or -> LATCH after bit 383.
- LATCH -> LOAD after the gap count.
REQ-019 WS2812_DATA is registered and is low in every state except SEND_HIGH.
REQ-020 With MAIN_CLK < 1 MHz, WS2812 output timing is undefined but the FSM still cycles. The time logic is unaffected.

Reset
REQ-021 While RST_N = 0:
- all time digits = 0 (00:00:00);
- LED = 5'b00000, driven from the registered BTN sample;
- WS2812_DATA = 0;
- FSM = IDLE; all counters cleared.
REQ-022 The first tick after RST_N rises advances from 00:00:00.
REQ-023 If reset is asserted mid-frame, the frame is abandoned immediately. After release a full new frame starts with LOAD.

Verification
REQ-024 MAIN_CLK=2, CLK_1HZ tied to CLK, BTN=1; 86400 ticks after reset -> time passes 23:59:59 and returns to 00:00:00, with dh1=2,dh0=3 seen before dh1=0,dh0=0.
REQ-025 BTN=1, time 00:00:59, one tick -> 00:01:00; from 00:59:59, one tick -> 01:00:00.
REQ-026 From 00:00:00, BTN driven low -> seconds held at 0, minutes +1 per tick; dh1=0,dh0=5 reached after 300 ticks; LED[4]=1 throughout.
REQ-027 MAIN_CLK=12000000, time 12:34:00:
- pixel 0 (dh1=1, row 0) = 24 bits 0x002000; pixel 1 = 0x000000.
- '1' bits high 9 cycles, '0' bits high 4 cycles, period 15 cycles.
- Latch gap >= 720 cycles low.
REQ-028 Assert RST_N low mid-frame and mid-count -> WS2812_DATA=0, time 00:00:00, LED=0 immediately, without waiting for a clock edge.
